// File: rtl/pipelined_addsub.sv
// Pipelined carry-propagate adder/subtractor: one SEG-bit segment per stage,
// registered inter-stage carry, valid/ready handshake and carry/overflow/zero flags.
`timescale 1ns/1ps
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero
);

  localparam int N = WIDTH / SEG;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Stage registers: index k holds the operation after stage k has run.
  logic [WIDTH-1:0] a_q [N];
  logic [WIDTH-1:0] b_q [N];
  logic [WIDTH-1:0] s_q [N];
  logic [N-1:0]     v_q, c_q, z_q;
  logic             ovf_q;

  // Stage inputs, and next-state values computed from them.
  logic [WIDTH-1:0] a_in [N];
  logic [WIDTH-1:0] b_in [N];
  logic [WIDTH-1:0] s_in [N];
  logic [N-1:0]     v_in, c_in, z_in;
  logic [WIDTH-1:0] nx_s [N];
  logic [N-1:0]     nx_c, nx_z;
  logic             nx_ovf;

  assign advance  = !v_q[N-1] || out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + 1; the borrow-in of sbb inverts into the carry-in.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    b_eff = in_b;
    c0    = 1'b0;
    case (op_e'(in_op))
      OP_ADD: c0 = 1'b0;
      OP_SUB: begin
        b_eff = ~in_b;
        c0    = 1'b1;
      end
      OP_ADC: c0 = in_cin;
      OP_SBB: begin
        b_eff = ~in_b;
        c0    = ~in_cin;
      end
      default: c0 = 1'b0;
    endcase
  end

  for (genvar k = 0; k < N; k++) begin : g_link
    if (k == 0) begin : g_head
      assign a_in[k] = in_a;
      assign b_in[k] = b_eff;
      assign s_in[k] = '0;
      assign c_in[k] = c0;
      assign z_in[k] = 1'b1;
      assign v_in[k] = in_valid;
    end else begin : g_tail
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign z_in[k] = z_q[k-1];
      assign v_in[k] = v_q[k-1];
    end
  end

  always_comb begin
    logic [SEG:0] seg_sum;
    seg_sum = '0;
    nx_c    = '0;
    nx_z    = '0;
    nx_ovf  = 1'b0;
    for (int k = 0; k < N; k++) begin
      seg_sum = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
              + (SEG+1)'(c_in[k]);
      nx_s[k] = s_in[k];
      nx_s[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      nx_c[k] = seg_sum[SEG];
      nx_z[k] = z_in[k] & ~|seg_sum[SEG-1:0];
      // Carry into the MSB is recovered from the MSB's own sum bit.
      if (k == N-1)
        nx_ovf = (a_in[k][WIDTH-1] ^ b_in[k][WIDTH-1] ^ seg_sum[SEG-1]) ^ seg_sum[SEG];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, so the result bus reads zero while in reset.
      for (int k = 0; k < N; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      v_q   <= '0;
      c_q   <= '0;
      z_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      // NOTE: sequential state uses non-blocking assignments so every stage shifts on the same edge.
      for (int k = 0; k < N; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= nx_s[k];
      end
      v_q   <= v_in;
      c_q   <= nx_c;
      z_q   <= nx_z;
      ovf_q <= nx_ovf;
    end
  end

  assign out_valid    = v_q[N-1];
  assign out_sum      = s_q[N-1];
  assign out_carry    = c_q[N-1];
  assign out_zero     = z_q[N-1];
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: drivers push expected results, monitors
// pop and compare on each output handshake. Covers a 32/8 and a 16/16 instance.
`timescale 1ns/1ps
module tb_pipelined_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
  } exp_t;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBB = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready;
  logic        out_carry, out_overflow, out_zero;
  logic [31:0] in_a, in_b, out_sum;
  logic [1:0]  in_op;

  logic        v16, rdy16, cin16, ov16, carry16, ovf16, zero16;
  logic [15:0] a16, b16, sum16;
  logic [1:0]  op16;

  int   checks = 0, failures = 0, pushed = 0, popped = 0;
  int   rdy_mode = 0;
  exp_t exp_q[$];
  logic [18:0] exp16_q[$];
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .SEG(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_overflow(out_overflow), .out_zero(out_zero));

  pipelined_addsub #(.WIDTH(16), .SEG(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
    .in_a(a16), .in_b(b16), .in_op(op16), .in_cin(cin16),
    .out_valid(ov16), .out_ready(1'b1), .out_sum(sum16),
    .out_carry(carry16), .out_overflow(ovf16), .out_zero(zero16));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t ex(input logic [31:0] s, input logic c, input logic o, input logic z);
    exp_t e;
    e.sum = s; e.carry = c; e.ovf = o; e.zero = z;
    return e;
  endfunction

  // Golden model for random operands: full-width add, overflow from operand/result signs.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic cin);
    logic [32:0] r;
    logic [31:0] be;
    logic        c;
    be = op[0] ? ~b : b;
    c  = op[1] ? (op[0] ? ~cin : cin) : op[0];
    r  = {1'b0, a} + {1'b0, be} + 33'(c);
    return ex(r[31:0], r[32], (a[31] == be[31]) && (r[31] != a[31]), r[31:0] == 32'd0);
  endfunction

  // Consumer ready: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = never ready.
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: samples mid-low-phase, ahead of the edge where a handshake completes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      check("in_ready", in_ready, !out_valid || out_ready);
      if (rst_n && prev_stall)
        check("hold", {out_valid, out_sum, out_carry, out_overflow, out_zero}, {1'b1, prev_out});
      prev_stall = rst_n && out_valid && !out_ready;
      prev_out   = {out_sum, out_carry, out_overflow, out_zero};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          popped++;
          check("result", {out_sum, out_carry, out_overflow, out_zero}, e);
        end
      end
      if (ov16) begin
        if (exp16_q.size() == 0) check("unexpected_out16", ov16, 1'b0);
        else check("result16", {sum16, carry16, ovf16, zero16}, exp16_q.pop_front());
      end
    end
  end

  // Called at negedge+1; returns at negedge+1 of the cycle after acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic cin, input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cin = cin;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1'b1);
    else begin
      @(posedge clk);
      exp_q.push_back(e);
      pushed++;
    end
    @(negedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         input logic [18:0] e);
    v16 = 1'b1; a16 = a; b16 = b; op16 = op; cin16 = 1'b0;
    @(posedge clk);
    exp16_q.push_back(e);
    #1;
    check("latency16", ov16, 1'b1);
    v16 = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp16_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("drain", exp_q.size() + exp16_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = ADD; in_cin = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; op16 = ADD; cin16 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", out_valid, 1'b0);
    check("reset_data", {out_sum, out_carry, out_overflow, out_zero}, '0);
    check("reset_valid16", ov16, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Latency with an empty pipeline, counting the acceptance edge.
    issue(32'hFFFF_FFFF, 32'h1, ADD, 1'b0, ex(32'h0, 1'b1, 1'b0, 1'b1));
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency32", n, 4);
    @(negedge clk);
    #1;

    issue(32'h7FFF_FFFF, 32'h1,         ADD, 1'b0, ex(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    issue(32'h5,         32'h7,         SUB, 1'b0, ex(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    issue(32'h8000_0000, 32'h1,         SUB, 1'b0, ex(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    issue(32'h0000_FFFF, 32'h0,         ADC, 1'b1, ex(32'h0001_0000, 1'b0, 1'b0, 1'b0));
    issue(32'h0,         32'h0,         SBB, 1'b1, ex(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
    issue(32'h5,         32'h5,         SBB, 1'b0, ex(32'h0,         1'b1, 1'b0, 1'b1));
    issue(32'hFFFF_FFFF, 32'h0,         ADC, 1'b1, ex(32'h0,         1'b1, 1'b0, 1'b1));
    issue(32'h1,         32'h1,         ADD, 1'b1, ex(32'h2,         1'b0, 1'b0, 1'b0));
    issue(32'h0,         32'h0,         ADD, 1'b0, ex(32'h0,         1'b0, 1'b0, 1'b1));
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, SUB, 1'b0, ex(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    issue(32'h0000_0100, 32'hFFFF_FF00, ADD, 1'b0, ex(32'h0,         1'b1, 1'b0, 1'b1));
    issue(32'h00FF_00FF, 32'h0001_0001, ADD, 1'b0, ex(32'h0100_0100, 1'b0, 1'b0, 1'b0));
    issue(32'h0,         32'h0,         SUB, 1'b1, ex(32'h0,         1'b1, 1'b0, 1'b1));
    drain();

    // Back-to-back stream against a stalling consumer.
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      logic [1:0]  op;
      logic        cin;
      a   = $urandom;
      b   = $urandom;
      op  = 2'($urandom_range(0, 3));
      cin = 1'($urandom_range(0, 1));
      issue(a, b, op, cin, model(a, b, op, cin));
    end
    rdy_mode = 0;
    drain();

    // Asynchronous reset with three operations in flight and the output stalled.
    rdy_mode = 2;
    @(negedge clk);
    #1;
    issue(32'h1, 32'h2, ADD, 1'b0, ex(32'h3, 1'b0, 1'b0, 1'b0));
    issue(32'h3, 32'h4, ADD, 1'b0, ex(32'h7, 1'b0, 1'b0, 1'b0));
    issue(32'h9, 32'h4, SUB, 1'b0, ex(32'h5, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    #3;
    check("inflight_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 1'b0);
    check("async_reset_data", {out_sum, out_carry, out_overflow, out_zero}, '0);
    pushed -= exp_q.size();
    exp_q.delete();
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("no_stale", out_valid, 1'b0);
    end

    // Single-stage configuration.
    issue16(16'hFFFF, 16'h0001, ADD, {16'h0000, 1'b1, 1'b0, 1'b1});
    issue16(16'h7FFF, 16'h0001, ADD, {16'h8000, 1'b0, 1'b1, 1'b0});
    issue16(16'h0000, 16'h0001, SUB, {16'hFFFF, 1'b0, 1'b0, 1'b0});
    drain();

    check("count", popped, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
